// File: rtl/othello_pkg.sv
// Shared Othello constants: cell codes, winner codes, board geometry, scanner FSM states.
package othello_pkg;

    localparam int unsigned BOARD_DIM   = 8;
    localparam int unsigned BOARD_CELLS = BOARD_DIM * BOARD_DIM;
    localparam int unsigned IDX_W       = $clog2(BOARD_CELLS);
    localparam int unsigned COORD_W     = $clog2(BOARD_DIM);
    localparam int unsigned CNT_W       = 7;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_BLACK = 2'b01;
    localparam logic [1:0] WIN_WHITE = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } scan_state_t;

endpackage

// File: rtl/score_scanner.sv
// Scans the 8x8 board store, counts black/white/empty cells and decides game-over/winner.
module score_scanner
    import othello_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               both_pass,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic [1:0]         rd_q,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   black_count,
    output logic [CNT_W-1:0]   white_count,
    output logic [CNT_W-1:0]   empty_count,
    output logic               board_full,
    output logic [1:0]         winner,
    output logic               win
);

    localparam int unsigned DCNT_W = 2;

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [DCNT_W-1:0]    r_dcnt;
    logic [RD_LATENCY-1:0] r_vld;
    logic [CNT_W-1:0]     r_blk;
    logic [CNT_W-1:0]     r_wht;
    logic [CNT_W-1:0]     r_emp;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_black_count;
    logic [CNT_W-1:0]     r_white_count;
    logic [CNT_W-1:0]     r_empty_count;
    logic                 r_board_full;
    logic [1:0]           r_winner;
    logic                 r_win;

    logic                 w_issue;
    logic                 w_sample;
    logic                 w_is_blk;
    logic                 w_is_wht;
    logic                 w_is_emp;
    logic                 w_scan_go;
    logic [CNT_W-1:0]     w_blk_nxt;
    logic [CNT_W-1:0]     w_wht_nxt;
    logic [CNT_W-1:0]     w_emp_nxt;
    logic                 w_over;
    logic [1:0]           w_winner;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, sample decode, running counts and the game-over decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = (r_state == ST_ISSUE);
        w_scan_go   = (r_state == ST_IDLE) && start;
        w_sample    = r_vld[RD_LATENCY-1];
        w_is_blk    = 1'b0;
        w_is_wht    = 1'b0;
        w_is_emp    = 1'b0;
        w_over      = 1'b0;
        w_winner    = WIN_NONE;

        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (r_idx == IDX_W'(BOARD_CELLS - 1)) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (r_dcnt == DCNT_W'(RD_LATENCY - 1)) w_state_nxt = ST_PUBLISH;
            ST_PUBLISH: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        // Code 11 is not a legal disk and counts as empty
        if (w_sample) begin
            w_is_blk = (rd_q == CELL_BLACK);
            w_is_wht = (rd_q == CELL_WHITE);
            w_is_emp = (rd_q == CELL_EMPTY) || (rd_q == 2'b11);
        end

        w_blk_nxt = r_blk + CNT_W'(w_is_blk);
        w_wht_nxt = r_wht + CNT_W'(w_is_wht);
        w_emp_nxt = r_emp + CNT_W'(w_is_emp);

        // Decision uses the counts including the final sample landing this cycle
        w_over = (w_emp_nxt == '0) || (w_blk_nxt == '0) || (w_wht_nxt == '0) || both_pass;
        if (w_over) begin
            if (w_blk_nxt > w_wht_nxt) begin
                w_winner = WIN_BLACK;
            end else if (w_wht_nxt > w_blk_nxt) begin
                w_winner = WIN_WHITE;
            end else begin
                w_winner = WIN_DRAW;
            end
        end
    end

    // Address index (wraps to 0 after the last cell) and drain counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_idx  <= '0;
            r_dcnt <= '0;
        end else begin
            r_idx  <= w_issue ? r_idx + IDX_W'(1) : '0;
            r_dcnt <= (r_state == ST_DRAIN) ? r_dcnt + DCNT_W'(1) : '0;
        end
    end

    // Valid tags travel alongside the read latency of the board store
    generate
        if (RD_LATENCY == 1) begin : g_vld_1
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= w_issue;
                end
            end
        end else begin : g_vld_n
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld[RD_LATENCY-2:0], w_issue};
                end
            end
        end
    endgenerate

    // Accumulators: cleared when a scan is launched, bumped on tagged samples
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_blk <= '0;
            r_wht <= '0;
            r_emp <= '0;
        end else if (w_scan_go) begin
            r_blk <= '0;
            r_wht <= '0;
            r_emp <= '0;
        end else begin
            r_blk <= w_blk_nxt;
            r_wht <= w_wht_nxt;
            r_emp <= w_emp_nxt;
        end
    end

    // Status flags and the published snapshot, which holds until the next publish
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_black_count <= '0;
            r_white_count <= '0;
            r_empty_count <= '0;
            r_board_full  <= 1'b0;
            r_winner      <= WIN_NONE;
            r_win         <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
            r_done <= (w_state_nxt == ST_PUBLISH);
            if (w_state_nxt == ST_PUBLISH) begin
                r_black_count <= w_blk_nxt;
                r_white_count <= w_wht_nxt;
                r_empty_count <= w_emp_nxt;
                r_board_full  <= (w_emp_nxt == '0);
                r_winner      <= w_winner;
                r_win         <= |w_winner;
            end
        end
    end

    assign rd_x        = r_idx[COORD_W-1:0];
    assign rd_y        = r_idx[IDX_W-1:COORD_W];
    assign busy        = r_busy;
    assign done        = r_done;
    assign black_count = r_black_count;
    assign white_count = r_white_count;
    assign empty_count = r_empty_count;
    assign board_full  = r_board_full;
    assign winner      = r_winner;
    assign win         = r_win;

endmodule

// File: tb/tb_score_scanner.sv
// Scoreboard bench: two scanners (read latency 1 and 3) share one board model.
module tb_score_scanner;

    typedef struct {
        int       b;
        int       w;
        int       e;
        int       full;
        int       winner;
        int       cyc;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       both_pass;
    logic [2:0] rx [2];
    logic [2:0] ry [2];
    logic [1:0] rq [2];
    logic       busy [2];
    logic       done [2];
    logic [6:0] bc [2];
    logic [6:0] wc [2];
    logic [6:0] ec [2];
    logic       full [2];
    logic [1:0] wnr [2];
    logic       win [2];

    logic [1:0] board [64];
    logic [1:0] mp1;
    logic [5:0] mp3;

    exp_t q0 [$];
    exp_t q1 [$];
    int   cyc;
    int   total;
    int   bad;
    int   off [2];
    logic pbusy [2];

    score_scanner #(.RD_LATENCY(1)) u_dut1 (
        .clock(clk), .resetn(resetn), .start(start), .both_pass(both_pass),
        .rd_x(rx[0]), .rd_y(ry[0]), .rd_q(rq[0]), .busy(busy[0]), .done(done[0]),
        .black_count(bc[0]), .white_count(wc[0]), .empty_count(ec[0]),
        .board_full(full[0]), .winner(wnr[0]), .win(win[0])
    );

    score_scanner #(.RD_LATENCY(3)) u_dut3 (
        .clock(clk), .resetn(resetn), .start(start), .both_pass(both_pass),
        .rd_x(rx[1]), .rd_y(ry[1]), .rd_q(rq[1]), .busy(busy[1]), .done(done[1]),
        .black_count(bc[1]), .white_count(wc[1]), .empty_count(ec[1]),
        .board_full(full[1]), .winner(wnr[1]), .win(win[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board store model with synchronous reads of latency 1 and 3
    always @(posedge clk) begin
        mp1 <= board[int'({ry[0], rx[0]})];
        mp3 <= {mp3[3:0], board[int'({ry[1], rx[1]})]};
    end
    assign rq[0] = mp1;
    assign rq[1] = mp3[5:4];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at cycle %0d", nm, k, act, exp, cyc);
        end
    endtask

    // Reference: count cells and apply the game-over rules directly
    function automatic exp_t model(input logic bp);
        exp_t r;
        int   over;
        r.b = 0; r.w = 0; r.e = 0;
        foreach (board[i]) begin
            if (board[i] == 2'b01)      r.b++;
            else if (board[i] == 2'b10) r.w++;
            else                        r.e++;
        end
        r.full = (r.e == 0) ? 1 : 0;
        over   = (r.e == 0 || r.b == 0 || r.w == 0 || bp) ? 1 : 0;
        if (!over)          r.winner = 0;
        else if (r.b > r.w) r.winner = 1;
        else if (r.w > r.b) r.winner = 2;
        else                r.winner = 3;
        r.cyc = 0;
        return r;
    endfunction

    // Monitor: address sequence every cycle, results whenever done pulses
    always @(negedge clk) begin
        if (!resetn) begin
            pbusy[0] = 1'b0;
            pbusy[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   ea;
                exp_t e;
                if (busy[k]) off[k] = pbusy[k] ? off[k] + 1 : 0;
                ea = (busy[k] && off[k] < 64) ? off[k] : 0;
                chk("addr", k, int'({ry[k], rx[k]}), ea);
                pbusy[k] = busy[k];
                if (done[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        chk("spurious_done", k, 1, 0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("done_cycle", k, cyc, e.cyc);
                        chk("busy_in_publish", k, int'(busy[k]), 0);
                        chk("black", k, int'(bc[k]), e.b);
                        chk("white", k, int'(wc[k]), e.w);
                        chk("empty", k, int'(ec[k]), e.e);
                        chk("board_full", k, int'(full[k]), e.full);
                        chk("winner", k, int'(wnr[k]), e.winner);
                        chk("win", k, int'(win[k]), (e.winner != 0) ? 1 : 0);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int extra);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) chk("scan_timeout", 0, n, 0);
        repeat (extra) @(posedge clk);
        #1;
    endtask

    // Launch a scan (start held for nscan scans); optional extra start pulse at cycle repulse
    task automatic run_scan(input logic bp, input int nscan, input int repulse, input int extra);
        exp_t ex;
        int   s;
        both_pass = bp;
        @(posedge clk); #1;
        start = 1'b1;
        s     = cyc;
        ex    = model(bp);
        for (int j = 0; j < nscan; j++) begin
            ex.cyc = s + (j + 1) * (65 + lat(0)) + j; q0.push_back(ex);
            ex.cyc = s + (j + 1) * (65 + lat(1)) + j; q1.push_back(ex);
        end
        if (nscan == 1) begin
            @(posedge clk); #1;
        end else begin
            repeat (100) @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (repulse >= 0) begin
            repeat (repulse) @(posedge clk);
            #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        wait_idle(extra);
    endtask

    task automatic fill(input logic [1:0] v);
        foreach (board[i]) board[i] = v;
    endtask

    task automatic place_random(input logic [1:0] v, input int n);
        int c;
        c = 0;
        while (c < n) begin
            int p;
            p = int'($urandom_range(0, 63));
            if (board[p] != v) begin
                board[p] = v;
                c++;
            end
        end
    endtask

    task automatic opening();
        fill(2'b00);
        board[27] = 2'b10; board[36] = 2'b10;
        board[35] = 2'b01; board[28] = 2'b01;
    endtask

    task automatic random_board(input int pb, input int pw);
        foreach (board[i]) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < pb)           board[i] = 2'b01;
            else if (r < pb + pw) board[i] = 2'b10;
            else                  board[i] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        end
    endtask

    initial begin
        exp_t ex;
        int   s;
        cyc = 0; total = 0; bad = 0;
        start = 1'b0; both_pass = 1'b0; resetn = 1'b0;
        off[0] = 0; off[1] = 0; pbusy[0] = 1'b0; pbusy[1] = 1'b0;
        mp1 = 2'b00; mp3 = '0;
        fill(2'b00);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, int'(busy[k]), 0);
            chk("rst_done", k, int'(done[k]), 0);
            chk("rst_counts", k, int'(bc[k]) + int'(wc[k]) + int'(ec[k]), 0);
            chk("rst_winner", k, int'({full[k], wnr[k], win[k]}), 0);
        end
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        opening();                       run_scan(1'b0, 1, -1, 3);
        fill(2'b10); place_random(2'b01, 40); run_scan(1'b0, 1, -1, 3);
        fill(2'b00); place_random(2'b01, 5);  run_scan(1'b0, 1, -1, 3);
        fill(2'b10); place_random(2'b01, 32); run_scan(1'b0, 1, -1, 3);
        opening();                       run_scan(1'b1, 1, -1, 3);
        fill(2'b11);                     run_scan(1'b0, 1, -1, 3);
        for (int t = 0; t < 6; t++) begin
            random_board(int'($urandom_range(0, 60)), int'($urandom_range(0, 40)));
            run_scan(logic'($urandom_range(0, 1)), 1, -1, 3);
        end
        random_board(45, 55);            run_scan(1'b0, 2, -1, 3);
        random_board(30, 30);            run_scan(1'b0, 1, 9, 80);

        // Abandon a scan with reset in cycle 30
        random_board(40, 40);
        both_pass = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        s     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s + 31) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk("busy_before_reset", k, int'(busy[k]), 1);
        resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_busy", k, int'(busy[k]), 0);
            chk("arst_done", k, int'(done[k]), 0);
            chk("arst_counts", k, int'(bc[k]) + int'(wc[k]) + int'(ec[k]), 0);
            chk("arst_flags", k, int'({full[k], wnr[k], win[k]}), 0);
            chk("arst_addr", k, int'({ry[k], rx[k]}), 0);
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (100) @(posedge clk);
        #1;

        random_board(35, 35);            run_scan(1'b0, 1, -1, 3);
        ex = model(1'b0);
        chk("final_hold_black", 0, int'(bc[0]), ex.b);
        chk("final_hold_black", 1, int'(bc[1]), ex.b);
        chk("queues_drained", 0, q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
